// File: rtl/mux_16.sv
// 16:1 WIDTH-bit selector with an optional output register; sel_i picks in0_i..in15_i.
// Used by the data cache to extract a byte, half-word or word from a 128-bit block.
module mux_16 #(
    parameter int WIDTH   = 8,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [3:0]       sel_i,
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic [WIDTH-1:0] in3_i,
    input  logic [WIDTH-1:0] in4_i,
    input  logic [WIDTH-1:0] in5_i,
    input  logic [WIDTH-1:0] in6_i,
    input  logic [WIDTH-1:0] in7_i,
    input  logic [WIDTH-1:0] in8_i,
    input  logic [WIDTH-1:0] in9_i,
    input  logic [WIDTH-1:0] in10_i,
    input  logic [WIDTH-1:0] in11_i,
    input  logic [WIDTH-1:0] in12_i,
    input  logic [WIDTH-1:0] in13_i,
    input  logic [WIDTH-1:0] in14_i,
    input  logic [WIDTH-1:0] in15_i,
    output logic [WIDTH-1:0] out_o
);

    logic [WIDTH-1:0] data [16];
    logic [WIDTH-1:0] sel;

    assign data[0]  = in0_i;
    assign data[1]  = in1_i;
    assign data[2]  = in2_i;
    assign data[3]  = in3_i;
    assign data[4]  = in4_i;
    assign data[5]  = in5_i;
    assign data[6]  = in6_i;
    assign data[7]  = in7_i;
    assign data[8]  = in8_i;
    assign data[9]  = in9_i;
    assign data[10] = in10_i;
    assign data[11] = in11_i;
    assign data[12] = in12_i;
    assign data[13] = in13_i;
    assign data[14] = in14_i;
    assign data[15] = in15_i;

    // Array indexing rather than a case: an X on sel_i reaches out_o instead of being masked.
    assign sel = data[sel_i];

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] out_q;

            // NOTE: non-blocking assignments in the clocked block; the async reset clears out_q
            // without a clock, and en_i=0 simply holds (no else branch needed for a flop).
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q <= '0;
                end else if (en_i) begin
                    out_q <= sel;
                end
            end

            assign out_o = out_q;
        end else begin : g_comb
            assign out_o = sel;
        end
    endgenerate

endmodule

// File: tb/tb_mux_16.sv
// Scoreboard bench for mux_16: combinational and registered instances at 8, 16 and 32 bits
// share one set of inputs; expectations are queued when driven and popped at the output.
module tb_mux_16;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  sel;
    logic [31:0] d [16];

    logic [7:0]  c8_out, r8_out;
    logic [15:0] c16_out, r16_out;
    logic [31:0] r32_out;

    logic [31:0] exp_q [$];
    logic [31:0] exp;
    int          vectors;
    int          miscompares;

    mux_16 #(.WIDTH(8), .REG_OUT(1'b0)) u_c8 (
        .clk(clk), .rst(rst), .en_i(en), .sel_i(sel),
        .in0_i(d[0][7:0]),   .in1_i(d[1][7:0]),   .in2_i(d[2][7:0]),   .in3_i(d[3][7:0]),
        .in4_i(d[4][7:0]),   .in5_i(d[5][7:0]),   .in6_i(d[6][7:0]),   .in7_i(d[7][7:0]),
        .in8_i(d[8][7:0]),   .in9_i(d[9][7:0]),   .in10_i(d[10][7:0]), .in11_i(d[11][7:0]),
        .in12_i(d[12][7:0]), .in13_i(d[13][7:0]), .in14_i(d[14][7:0]), .in15_i(d[15][7:0]),
        .out_o(c8_out)
    );

    mux_16 #(.WIDTH(8), .REG_OUT(1'b1)) u_r8 (
        .clk(clk), .rst(rst), .en_i(en), .sel_i(sel),
        .in0_i(d[0][7:0]),   .in1_i(d[1][7:0]),   .in2_i(d[2][7:0]),   .in3_i(d[3][7:0]),
        .in4_i(d[4][7:0]),   .in5_i(d[5][7:0]),   .in6_i(d[6][7:0]),   .in7_i(d[7][7:0]),
        .in8_i(d[8][7:0]),   .in9_i(d[9][7:0]),   .in10_i(d[10][7:0]), .in11_i(d[11][7:0]),
        .in12_i(d[12][7:0]), .in13_i(d[13][7:0]), .in14_i(d[14][7:0]), .in15_i(d[15][7:0]),
        .out_o(r8_out)
    );

    mux_16 #(.WIDTH(16), .REG_OUT(1'b0)) u_c16 (
        .clk(clk), .rst(rst), .en_i(en), .sel_i(sel),
        .in0_i(d[0][15:0]),   .in1_i(d[1][15:0]),   .in2_i(d[2][15:0]),   .in3_i(d[3][15:0]),
        .in4_i(d[4][15:0]),   .in5_i(d[5][15:0]),   .in6_i(d[6][15:0]),   .in7_i(d[7][15:0]),
        .in8_i(d[8][15:0]),   .in9_i(d[9][15:0]),   .in10_i(d[10][15:0]), .in11_i(d[11][15:0]),
        .in12_i(d[12][15:0]), .in13_i(d[13][15:0]), .in14_i(d[14][15:0]), .in15_i(d[15][15:0]),
        .out_o(c16_out)
    );

    mux_16 #(.WIDTH(16), .REG_OUT(1'b1)) u_r16 (
        .clk(clk), .rst(rst), .en_i(en), .sel_i(sel),
        .in0_i(d[0][15:0]),   .in1_i(d[1][15:0]),   .in2_i(d[2][15:0]),   .in3_i(d[3][15:0]),
        .in4_i(d[4][15:0]),   .in5_i(d[5][15:0]),   .in6_i(d[6][15:0]),   .in7_i(d[7][15:0]),
        .in8_i(d[8][15:0]),   .in9_i(d[9][15:0]),   .in10_i(d[10][15:0]), .in11_i(d[11][15:0]),
        .in12_i(d[12][15:0]), .in13_i(d[13][15:0]), .in14_i(d[14][15:0]), .in15_i(d[15][15:0]),
        .out_o(r16_out)
    );

    mux_16 #(.WIDTH(32), .REG_OUT(1'b1)) u_r32 (
        .clk(clk), .rst(rst), .en_i(en), .sel_i(sel),
        .in0_i(d[0]),   .in1_i(d[1]),   .in2_i(d[2]),   .in3_i(d[3]),
        .in4_i(d[4]),   .in5_i(d[5]),   .in6_i(d[6]),   .in7_i(d[7]),
        .in8_i(d[8]),   .in9_i(d[9]),   .in10_i(d[10]), .in11_i(d[11]),
        .in12_i(d[12]), .in13_i(d[13]), .in14_i(d[14]), .in15_i(d[15]),
        .out_o(r32_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        sel = 4'h0;
        for (int k = 0; k < 16; k++) d[k] = $urandom;
        #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front();
        vectors++;
        if ({r8_out, r16_out, r32_out} !== {exp[7:0], exp[15:0], exp}) begin
            miscompares++;
            $display("FAIL reset_async got r8=%h r16=%h r32=%h want 0", r8_out, r16_out, r32_out);
        end
        // Clock edges with en_i=1 must be ignored while rst is high.
        @(negedge clk);
        en  = 1'b1;
        sel = 4'h7;
        exp_q.push_back(32'h0);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        vectors++;
        if (r32_out !== exp) begin
            miscompares++;
            $display("FAIL reset_hold got=%h want=%h", r32_out, exp);
        end
        // After release, out stays 0 until the first enabled load.
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        exp_q.push_back(32'h0);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        vectors++;
        if ({r8_out, r16_out, r32_out} !== {exp[7:0], exp[15:0], exp}) begin
            miscompares++;
            $display("FAIL reset_release got r8=%h r16=%h r32=%h want 0", r8_out, r16_out, r32_out);
        end
    endtask

    task automatic test_comb_sweep();
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 16; k++) d[k] = 32'h10 + 32'(k);
        for (int s = 0; s < 16; s++) begin
            sel = 4'(s);
            exp_q.push_back(32'h10 + 32'(s));
            #1;
            exp = exp_q.pop_front();
            vectors++;
            if ({24'h0, c8_out} !== exp) begin
                miscompares++;
                $display("FAIL comb_sweep sel=%0d got=%h want=%h", s, c8_out, exp[7:0]);
            end
        end
    endtask

    task automatic test_reg_latency();
        logic [31:0] prev;
        @(negedge clk);
        prev  = r32_out;
        sel   = 4'h5;
        d[5]  = 32'hDEADBEEF;
        en    = 1'b1;
        exp_q.push_back(prev);
        exp_q.push_back(32'hDEADBEEF);
        #1;
        exp = exp_q.pop_front();
        vectors++;
        if (r32_out !== exp) begin
            miscompares++;
            $display("FAIL latency_before got=%h want=%h", r32_out, exp);
        end
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        vectors++;
        if (r32_out !== exp) begin
            miscompares++;
            $display("FAIL latency_after got=%h want=%h", r32_out, exp);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        sel  = 4'h3;
        d[3] = 32'hA5;
        en   = 1'b1;
        exp_q.push_back(32'hA5);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        vectors++;
        if ({24'h0, r8_out} !== exp) begin
            miscompares++;
            $display("FAIL hold_load got=%h want=%h", r8_out, exp[7:0]);
        end
        @(negedge clk);
        en   = 1'b0;
        sel  = 4'h9;
        d[9] = 32'h3C;
        for (int c = 0; c < 5; c++) begin
            exp_q.push_back(32'hA5);
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            vectors++;
            if ({24'h0, r8_out} !== exp) begin
                miscompares++;
                $display("FAIL hold_cycle%0d got=%h want=%h", c, r8_out, exp[7:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        sel  = 4'h2;
        d[2] = 32'hBEEF;
        en   = 1'b1;
        exp_q.push_back(32'hBEEF);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        vectors++;
        if ({16'h0, r16_out} !== exp) begin
            miscompares++;
            $display("FAIL arst_load got=%h want=%h", r16_out, exp[15:0]);
        end
        // Assert rst between edges: out must clear before the next edge.
        #2;
        rst = 1'b1;
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front();
        vectors++;
        if ({16'h0, r16_out} !== exp) begin
            miscompares++;
            $display("FAIL arst_clear got=%h want=%h", r16_out, exp[15:0]);
        end
        exp_q.push_back(32'h0);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        vectors++;
        if ({16'h0, r16_out} !== exp) begin
            miscompares++;
            $display("FAIL arst_en_ignored got=%h want=%h", r16_out, exp[15:0]);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hBEEF);
        #1;
        exp = exp_q.pop_front();
        vectors++;
        if ({16'h0, r16_out} !== exp) begin
            miscompares++;
            $display("FAIL arst_release_pre got=%h want=%h", r16_out, exp[15:0]);
        end
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        vectors++;
        if ({16'h0, r16_out} !== exp) begin
            miscompares++;
            $display("FAIL arst_release_load got=%h want=%h", r16_out, exp[15:0]);
        end
    endtask

    task automatic test_boundary();
        logic [3:0]  sels [2];
        logic [31:0] vals [2];
        sels[0] = 4'hF; vals[0] = 32'h0000FFFF;
        sels[1] = 4'h0; vals[1] = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            en   = 1'b1;
            d[0] = 32'h1234;
            d[15] = 32'h5678;
            sel  = sels[i];
            d[sels[i]] = vals[i];
            exp_q.push_back(vals[i]);
            exp_q.push_back(vals[i]);
            #1;
            exp = exp_q.pop_front();
            vectors++;
            if ({16'h0, c16_out} !== exp) begin
                miscompares++;
                $display("FAIL boundary_comb sel=%h got=%h want=%h", sels[i], c16_out, exp[15:0]);
            end
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            vectors++;
            if ({16'h0, r16_out} !== exp) begin
                miscompares++;
                $display("FAIL boundary_reg sel=%h got=%h want=%h", sels[i], r16_out, exp[15:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] model;
        model = 32'h0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 16; k++) d[k] = $urandom;
            sel = 4'($urandom_range(0, 15));
            en  = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (en) model = d[sel];
            exp_q.push_back(model);
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            vectors++;
            if (r32_out !== exp) begin
                miscompares++;
                $display("FAIL random_cycle%0d got=%h want=%h", c, r32_out, exp);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_comb_sweep();
        test_reg_latency();
        test_hold();
        test_async_reset();
        test_boundary();
        test_random();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
